// File: rtl/ogr_job_dispatcher.sv
// OGR job link initiator: sends a job packet MSB-first through the UART transmit
// interface, then collects the result packet with echo check and per-byte timeout.
module ogr_job_dispatcher #(
    parameter int          JOB_BYTES      = 6,
    parameter int          RESULT_BYTES   = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd120000000
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      job_valid_i,
    output logic                      job_ready_o,
    input  logic [8*JOB_BYTES-1:0]    job_data_i,
    output logic                      busy_o,
    output logic                      result_valid_o,
    output logic [8*RESULT_BYTES-1:0] result_data_o,
    output logic                      result_echo_ok_o,
    output logic                      error_timeout_o,
    output logic                      error_rx_o,
    output logic                      transmit_o,
    output logic [7:0]                tx_byte_o,
    input  logic                      is_transmitting_i,
    input  logic                      received_i,
    input  logic [7:0]                rx_byte_i,
    input  logic                      recv_error_i
);

    localparam int JW   = 8 * JOB_BYTES;
    localparam int RW   = 8 * RESULT_BYTES;
    localparam int MAXB = (JOB_BYTES > RESULT_BYTES) ? JOB_BYTES : RESULT_BYTES;
    localparam int CW   = $clog2(MAXB + 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_LOAD,
        TX_WAIT_BUSY,
        TX_WAIT_IDLE,
        RX,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [JW-1:0]   tx_shift_q, tx_shift_d;
    logic [15:0]     echo_ref_q, echo_ref_d;
    logic [RW-1:0]   result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     tout_q, tout_d;
    logic            err_to_q, err_to_d;
    logic            err_rx_q, err_rx_d;
    logic            transmit_q, transmit_d;
    logic [7:0]      tx_byte_q, tx_byte_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            echo_ref_q <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            tout_q     <= '0;
            err_to_q   <= 1'b0;
            err_rx_q   <= 1'b0;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            echo_ref_q <= echo_ref_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            tout_q     <= tout_d;
            err_to_q   <= err_to_d;
            err_rx_q   <= err_rx_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        echo_ref_d = echo_ref_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        tout_d     = tout_q;
        err_to_d   = err_to_q;
        err_rx_d   = err_rx_q;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;

        case (state_q)
            IDLE: begin
                if (job_valid_i) begin
                    tx_shift_d = job_data_i;
                    echo_ref_d = job_data_i[JW-1 -: 16];
                    result_d   = '0;
                    err_to_d   = 1'b0;
                    err_rx_d   = 1'b0;
                    cnt_d      = '0;
                    state_d    = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!is_transmitting_i) begin
                    tx_byte_d  = tx_shift_q[JW-1 -: 8];
                    tx_shift_d = {tx_shift_q[JW-9:0], 8'h00};
                    transmit_d = 1'b1;
                    state_d    = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (is_transmitting_i) begin
                    state_d = TX_WAIT_IDLE;
                end
            end
            TX_WAIT_IDLE: begin
                if (!is_transmitting_i) begin
                    if (cnt_q == CW'(JOB_BYTES - 1)) begin
                        cnt_d   = '0;
                        tout_d  = '0;
                        state_d = RX;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = TX_LOAD;
                    end
                end
            end
            RX: begin
                if (recv_error_i) begin
                    err_rx_d = 1'b1;
                end
                // A byte arriving on the terminal-count cycle wins over the timeout.
                if (cnt_q == CW'(RESULT_BYTES)) begin
                    state_d = DONE;
                end else if (received_i) begin
                    for (int k = 0; k < RESULT_BYTES; k++) begin
                        if (cnt_q == CW'(k)) begin
                            result_d[RW-1-8*k -: 8] = rx_byte_i;
                        end
                    end
                    cnt_d  = cnt_q + CW'(1);
                    tout_d = '0;
                end else begin
                    if (tout_q != '1) begin
                        tout_d = tout_q + 32'd1;
                    end
                    if ((TIMEOUT_CYCLES != 32'd0) && (tout_d >= TIMEOUT_CYCLES)) begin
                        err_to_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign job_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign result_valid_o   = (state_q == DONE);
    assign result_data_o    = result_q;
    assign result_echo_ok_o = (state_q == DONE) && (result_q[RW-1 -: 16] == echo_ref_q);
    assign error_timeout_o  = err_to_q;
    assign error_rx_o       = err_rx_q;
    assign transmit_o       = transmit_q;
    assign tx_byte_o        = tx_byte_q;

endmodule

// File: tb/tb_ogr_job_dispatcher.sv
// Self-checking bench for ogr_job_dispatcher: a UART model on the link side plus
// directed and randomized job vectors checked against a packet-level reference model.
module tb_ogr_job_dispatcher;

    localparam int TOUT = 100;

    typedef struct {
        logic [47:0] job;
        logic [63:0] reply;
        int          nBytes;
        int          errIdx;
        bit          stray;
        logic [63:0] expResult;
        bit          expEcho;
        bit          expTo;
        bit          expRx;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_i;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [47:0] job_data_i;
    logic        busy_o;
    logic        result_valid_o;
    logic [63:0] result_data_o;
    logic        result_echo_ok_o;
    logic        error_timeout_o;
    logic        error_rx_o;
    logic        transmit_o;
    logic [7:0]  tx_byte_o;
    logic        is_transmitting_i;
    logic        received_i;
    logic [7:0]  rx_byte_i;
    logic        recv_error_i;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycleCount = 0;
    int          rvPulses = 0;
    int          overlaps = 0;
    int          busyLeft = 0;
    logic [7:0]  txLog[$];
    vec_t        vecs[$];

    ogr_job_dispatcher #(
        .JOB_BYTES     (6),
        .RESULT_BYTES  (8),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clock_i          (clock),
        .reset_i          (reset_i),
        .job_valid_i      (job_valid_i),
        .job_ready_o      (job_ready_o),
        .job_data_i       (job_data_i),
        .busy_o           (busy_o),
        .result_valid_o   (result_valid_o),
        .result_data_o    (result_data_o),
        .result_echo_ok_o (result_echo_ok_o),
        .error_timeout_o  (error_timeout_o),
        .error_rx_o       (error_rx_o),
        .transmit_o       (transmit_o),
        .tx_byte_o        (tx_byte_o),
        .is_transmitting_i(is_transmitting_i),
        .received_i       (received_i),
        .rx_byte_i        (rx_byte_i),
        .recv_error_i     (recv_error_i)
    );

    always #5 clock = ~clock;

    // UART transmitter model: logs every strobe and stays busy for a random time.
    initial begin
        is_transmitting_i = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cycleCount++;
            if (result_valid_o) rvPulses++;
            if (reset_i) begin
                is_transmitting_i = 1'b0;
                busyLeft = 0;
            end else if (transmit_o) begin
                if (is_transmitting_i) overlaps++;
                txLog.push_back(tx_byte_o);
                is_transmitting_i = 1'b1;
                busyLeft = $urandom_range(2, 6);
            end else if (is_transmitting_i) begin
                busyLeft--;
                if (busyLeft <= 0) is_transmitting_i = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t refModel(input vec_t v);
        vec_t r = v;
        r.expResult = (v.nBytes >= 8) ? v.reply : (v.reply & ~({64{1'b1}} >> (8 * v.nBytes)));
        r.expEcho   = (r.expResult[63:48] == v.job[47:32]);
        r.expTo     = (v.nBytes < 8);
        r.expRx     = (v.errIdx >= 0) && (v.errIdx < v.nBytes);
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v, input bit alreadyAccepted, input bit holdNext,
                                 input logic [47:0] nextJob);
        int base;
        int lastRx = 0;
        int i;
        logic [7:0] b;
        if (!alreadyAccepted) begin
            job_data_i  = v.job;
            job_valid_i = 1'b1;
            for (i = 0; i < 50 && !job_ready_o; i++) tick();
            checkOutput("job_ready_wait", job_ready_o, 1);
            txLog.delete();
            tick();
            job_valid_i = holdNext;
        end
        base = rvPulses;
        for (i = 0; i < 3000 && txLog.size() < 6; i++) begin
            received_i = v.stray && (i % 3 == 1);
            rx_byte_i  = 8'hEE;
            tick();
        end
        received_i = 1'b0;
        for (i = 0; i < 50 && is_transmitting_i; i++) tick();
        repeat (3) tick();
        checkOutput("tx_count", txLog.size(), 6);
        for (int k = 0; k < 6; k++) begin
            b = 'x;
            if (k < txLog.size()) b = txLog[k];
            checkOutput($sformatf("tx_byte%0d", k), b, v.job[47-8*k -: 8]);
        end
        checkOutput("tx_overlap", overlaps, 0);
        for (int k = 0; k < v.nBytes; k++) begin
            repeat ($urandom_range(0, 4)) tick();
            received_i   = 1'b1;
            rx_byte_i    = v.reply[63-8*k -: 8];
            recv_error_i = (k == v.errIdx);
            lastRx       = cycleCount;
            tick();
            received_i   = 1'b0;
            recv_error_i = 1'b0;
        end
        for (i = 0; i < 400 && !result_valid_o; i++) tick();
        checkOutput("result_valid_seen", result_valid_o, 1);
        checkOutput("result_data", result_data_o, v.expResult);
        checkOutput("echo_ok", result_echo_ok_o, v.expEcho);
        checkOutput("error_timeout", error_timeout_o, v.expTo);
        checkOutput("error_rx", error_rx_o, v.expRx);
        if (v.expTo)
            checkOutput("timeout_latency",
                        (cycleCount - lastRx >= TOUT) && (cycleCount - lastRx <= TOUT + 3), 1);
        if (holdNext) job_data_i = nextJob;
        tick();
        checkOutput("ready_after_rv", job_ready_o, 1);
        checkOutput("rv_one_cycle", result_valid_o, 0);
        tick();
        checkOutput("rv_pulses", rvPulses - base, 1);
        if (holdNext) begin
            checkOutput("second_accept", busy_o, 1);
            txLog.delete();
            job_valid_i = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        reset_i      = 1'b1;
        job_valid_i  = 1'b0;
        job_data_i   = '0;
        received_i   = 1'b0;
        rx_byte_i    = '0;
        recv_error_i = 1'b0;

        vecs.push_back('{48'h0037_0000_0103, 64'h0037_0005_0102_0304, 8, -1, 1'b0,
                         64'h0037_0005_0102_0304, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{48'h0037_0000_0103, 64'h0038_0005_0102_0304, 8, -1, 1'b0,
                         64'h0038_0005_0102_0304, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{48'h0037_0000_0103, 64'hAABB_CC00_0000_0000, 3, -1, 1'b0,
                         64'hAABB_CC00_0000_0000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{48'h1122_3344_5566, 64'h1122_0A0B_0C0D_0E0F, 8, 3, 1'b1,
                         64'h1122_0A0B_0C0D_0E0F, 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 8; i++) begin
            v.job   = {16'($urandom), 32'($urandom)};
            v.reply = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) v.reply[63:48] = v.job[47:32];
            v.nBytes = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            v.errIdx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            v.stray  = 1'($urandom_range(0, 1));
            vecs.push_back(refModel(v));
        end

        repeat (3) tick();
        checkOutput("rst_transmit", transmit_o, 0);
        checkOutput("rst_tx_byte", tx_byte_o, 0);
        checkOutput("rst_result_valid", result_valid_o, 0);
        checkOutput("rst_result_data", result_data_o, 0);
        checkOutput("rst_echo_ok", result_echo_ok_o, 0);
        checkOutput("rst_error_timeout", error_timeout_o, 0);
        checkOutput("rst_error_rx", error_rx_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_job_ready", job_ready_o, 1);
        reset_i = 1'b0;
        tick();

        foreach (vecs[i]) applyStimulus(vecs[i], 1'b0, 1'b0, '0);

        // Reset in the middle of the third transmitted byte.
        job_data_i  = vecs[3].job;
        job_valid_i = 1'b1;
        for (int i = 0; i < 50 && !job_ready_o; i++) tick();
        txLog.delete();
        tick();
        job_valid_i = 1'b0;
        for (int i = 0; i < 500 && txLog.size() < 3; i++) tick();
        checkOutput("midrst_reached_byte3", txLog.size(), 3);
        reset_i = 1'b1;
        tick();
        checkOutput("midrst_transmit", transmit_o, 0);
        checkOutput("midrst_busy", busy_o, 0);
        reset_i = 1'b0;
        tick();
        checkOutput("midrst_job_ready", job_ready_o, 1);
        checkOutput("midrst_result_data", result_data_o, 0);
        applyStimulus(vecs[0], 1'b0, 1'b0, '0);

        // job_valid held high across two consecutive jobs.
        applyStimulus(vecs[0], 1'b0, 1'b1, vecs[1].job);
        applyStimulus(vecs[1], 1'b1, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ogr_job_dispatcher.md
Name: ogr_job_dispatcher

Overview:
- Initiator side of the OGR job link. Serializes a 48-bit job packet into the UART core's transmit interface, then collects the 64-bit result packet from the UART core's receive interface.
- Hands the result packet back to a host-side controller, with echo checking and a per-byte timeout.
- Instantiated alongside a uart core instance, either on a master/test FPGA or in the system bench, facing the ruler board.

Parameters:
- JOB_BYTES, 6, bytes per job packet; job_data width is 8*JOB_BYTES.
- RESULT_BYTES, 8, bytes per result packet; result_data width is 8*RESULT_BYTES.
- TIMEOUT_CYCLES, 32'd120000000, max clocks to wait for each result byte; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  high in IDLE only; job accepted when job_valid && job_ready
- job_data  in  48  job packet; bits [47:32] = maxdistance, rest = fixed-prefix marks
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle pulse when a packet exchange ends (success or error)
- result_data  out  64  received packet; holds its value until the next job is accepted
- result_echo_ok  out  1  result_data[63:48] == latched job_data[47:32]; valid with result_valid
- error_timeout  out  1  sticky per job; set if a result byte was late
- error_rx  out  1  sticky per job; set if recv_error was seen during RX
- transmit  out  1  UART transmit strobe
- tx_byte  out  8  UART byte to send
- is_transmitting  in  1  UART transmitter busy
- received  in  1  UART byte-received pulse
- rx_byte  in  8  UART received byte
- recv_error  in  1  UART receive error

Behaviour:
- Reset values:
  - Outputs: transmit=0, tx_byte=0, result_valid=0, result_data=0, result_echo_ok=0, error_timeout=0, error_rx=0, busy=0, job_ready=1.
  - Internal: state=IDLE, byte counter=0, timeout counter=0.
- States: IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE, RX, DONE.
- IDLE, on acceptance:
  - Latch job_data into a shift register.
  - Clear result_data and both error flags.
  - Set byte count to 0 and go to TX_LOAD.
- Byte order is MSB first on both directions:
  - TX: byte k sent = job[47-8k -: 8].
  - RX: byte k received lands in result[63-8k -: 8].
- TX_LOAD: when is_transmitting=0, drive tx_byte with the current byte, set transmit=1 for exactly one cycle, go to TX_WAIT_BUSY.
- TX_WAIT_BUSY:
  - transmit=0.
  - Wait for is_transmitting=1, then go to TX_WAIT_IDLE.
  - There is no timeout here; the UART core always responds.
- TX_WAIT_IDLE: wait for is_transmitting=0, then increment the byte count.
  - If count == JOB_BYTES: clear the count and timeout counter, go to RX.
  - Otherwise go to TX_LOAD.
- Bytes are never overlapped; each byte's full busy/idle cycle completes before the next strobe.
- Any received pulse in IDLE, the TX states or DONE is discarded; it does not shift into result_data.
- RX:
  - On received=1: store rx_byte at position count, increment count, clear the timeout counter.
  - When count reaches RESULT_BYTES, go to DONE on the next edge.
  - The timeout counter increments every cycle with no received pulse. Reaching TIMEOUT_CYCLES (nonzero) sets error_timeout and goes to DONE; bytes already captured are kept, the rest stay 0.
  - recv_error=1 sets error_rx but does not abort; a byte can still be received that cycle.
  - If received and the timeout terminal count occur in the same cycle, the byte is taken and the timeout is not set.
- DONE:
  - result_valid=1 for one cycle.
  - result_echo_ok is computed from the stored data.
  - Go to IDLE; job_ready rises the cycle after result_valid.
- Reset mid-operation: immediate return to the reset values. transmit deasserts in the same cycle reset is sampled, and a byte in flight in the UART is abandoned.
- The timeout counter is 32 bits and saturates; it never wraps.

Test Plan:
- Job 48'h0037_0000_0103, bench UART model echoes 8 bytes 00 37 00 05 01 02 03 04 -> TX bytes 00,37,00,00,01,03 in order, one transmit pulse each; result_data=64'h0037_0005_0102_0304, result_echo_ok=1, both errors 0, single result_valid pulse.
- Same job, reply starts with 00 38 -> result_echo_ok=0, result_valid still pulses, errors 0.
- TIMEOUT_CYCLES=100, model sends only 3 bytes AA BB CC -> error_timeout=1 about 100 cycles after the 3rd byte; result_data=64'hAABB_CC00_0000_0000.
- Stray received pulses during TX phase plus recv_error on RX byte 4 -> stray bytes absent from result_data, error_rx=1, all 8 reply bytes captured.
- Reset asserted during TX byte 3 -> transmit=0 and busy=0 that cycle, job_ready=1 next cycle; a new job then runs cleanly from byte 0.
- job_valid held high through two consecutive jobs -> second job accepted exactly one cycle after the first result_valid; no byte overlap on tx.
